fifo_uart_tx: RTL and testbench

Downstream consumer of the byte FIFO. It pops words from the FIFO read port and serializes each one as an asynchronous UART frame on a single line. The frame is: start bit, data LSB-first, optional even parity, then 1 or 2 stop bits. It sits between the FIFO and the board TX pin. The block is the sole master of the FIFO's re input.

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops words from a byte FIFO and serializes each one as an asynchronous UART
// frame: start bit (0), DATA_WIDTH data bits LSB first, an optional even parity
// bit, then STOP_BITS stop bits (1). The line idles high.
//
// FIFO handshake: in IDLE, a new word is requested only when enable=1 and
// fifo_empty=0 on the same rising edge. fifo_re is then high for exactly one
// cycle (the REQ state). The FIFO registers its output, so fifo_data is valid
// during the following cycle (FETCH) and is captured at the end of it.
// fifo_data is ignored in every other state, and fifo_empty outside IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   enable     allows new frames to start (sampled only in IDLE)
//   fifo_empty FIFO empty flag
//   fifo_data  FIFO registered read data
//   fifo_re    FIFO read strobe (registered, one cycle per word)
//   tx         serial line (registered, idle high)
//   busy       high whenever the FSM is not in IDLE
//   state_dbg  current FSM state (IDLE=0, REQ=1, FETCH=2, START=3, DATA=4,
//              PARITY=5, STOP=6)
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_re,
    output logic                  tx,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_FETCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t                state_q,   state_d;
    logic [BAUD_W-1:0]     baud_q,    baud_d;
    logic [BIT_W-1:0]      bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  parity_q,  parity_d;
    logic                  fifo_re_q, fifo_re_d;
    logic                  tx_q,      tx_d;
    logic                  baud_done;
    logic                  timed;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        fifo_re_d = 1'b0;
        tx_d      = 1'b1;
        baud_done = (baud_q == BAUD_LAST);
        timed     = 1'b0;
        baud_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d   = S_REQ;
                    // Registered strobe: high during the REQ cycle only.
                    fifo_re_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                shift_d  = fifo_data;
                parity_d = (PARITY_EN != 0) ? ^fifo_data : 1'b0;
                state_d  = S_START;
            end
            S_START: begin
                timed = 1'b1;
                tx_d  = 1'b0;
                if (baud_done) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                timed = 1'b1;
                tx_d  = shift_q[0];
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        // bit_q is reused to count stop bits.
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                timed = 1'b1;
                tx_d  = parity_q;
                if (baud_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                timed = 1'b1;
                tx_d  = 1'b1;
                if (baud_done) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Baud counter restarts on every state change and on every bit wrap.
        if (timed && (state_d == state_q) && !baud_done) begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            fifo_re_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            fifo_re_q <= fifo_re_d;
            tx_q      <= tx_d;
        end
    end

    assign fifo_re   = fifo_re_q;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two lanes, each with its own DUT and FIFO model:
//   lane 0: CLKS_PER_BIT=4, no parity, 1 stop bit
//   lane 1: CLKS_PER_BIT=4, even parity, 2 stop bits
// Each lane pushes words into its FIFO model and into an expected queue; a
// line monitor watches tx, pops the expected word at each start bit and
// compares every cycle of the frame against the ideal UART bit sequence.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB         = 4;
    localparam int WAIT_BUDGET = 3000;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   lane_done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int PE    = g;
        localparam int SB    = g + 1;
        localparam int NBITS = 1 + 8 + PE + SB;

        logic             rst = 1'b0;
        logic             en = 1'b0;
        logic             fifo_empty = 1'b1;
        logic [7:0]       fifo_data = 8'h00;
        logic             fifo_re;
        logic             tx;
        logic             busy;
        logic [2:0]       state_dbg;

        logic [7:0]       mem_q [$];
        logic [7:0]       exp_q [$];
        int               re_cnt = 0;
        logic             prev_re = 1'b0;

        int               pos = -1;
        int               idle_run = 0;
        int               mism = 0;
        int               frames_done = 0;
        int               start_cyc = 0;
        int               last_gap = 0;
        logic             bit9 = 1'b0;
        logic [7:0]       cur = 8'h00;
        logic [NBITS-1:0] wave = '1;

        fifo_uart_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (en),
            .fifo_empty(fifo_empty),
            .fifo_data (fifo_data),
            .fifo_re   (fifo_re),
            .tx        (tx),
            .busy      (busy),
            .state_dbg (state_dbg)
        );

        task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
            check($sformatf("lane%0d_%s", g, name), act, exp);
        endtask

        // Ideal frame, bit 0 first on the line.
        function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
            logic [NBITS-1:0] w;
            w    = '1;
            w[0] = 1'b0;
            for (int i = 0; i < 8; i++) w[1 + i] = b[i];
            if (PE != 0) w[9] = ^b;
            return w;
        endfunction

        task automatic push(input logic [7:0] b);
            mem_q.push_back(b);
            exp_q.push_back(b);
        endtask

        task automatic wait_frames(input int target, input string tag);
            int b = 0;
            while (frames_done < target && b < WAIT_BUDGET) begin
                @(negedge clk);
                b++;
            end
            chk(tag, frames_done, target);
        endtask

        task automatic wait_pos(input int target, input string tag);
            int b = 0;
            while (pos < target && b < 500) begin
                @(negedge clk);
                b++;
            end
            chk(tag, pos >= target, 1);
        endtask

        // FIFO model: registered read data, random garbage when not reading.
        always @(posedge clk) begin
            if (fifo_re === 1'b1) begin
                chk("re_when_empty", mem_q.size() > 0, 1);
                chk("re_two_cycles", prev_re, 0);
                re_cnt++;
                if (mem_q.size() > 0) fifo_data <= mem_q.pop_front();
            end else begin
                fifo_data <= 8'($urandom);
            end
            prev_re = fifo_re;
        end

        // Empty flag settles between edges after any push or pop.
        always @(negedge clk) begin
            #1 fifo_empty = (mem_q.size() == 0);
        end

        // Line monitor / scoreboard.
        always @(negedge clk) begin
            if (rst) begin
                pos      = -1;
                idle_run = 0;
            end else if (pos < 0) begin
                if (tx === 1'b0) begin
                    start_cyc = cyc;
                    last_gap  = idle_run;
                    idle_run  = 0;
                    mism      = 0;
                    pos       = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                        cur = 8'h00;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    wave = frame_bits(cur);
                end else begin
                    idle_run++;
                end
            end else begin
                if (pos == 9 * CPB + CPB / 2) bit9 = tx;
                if (tx !== wave[pos / CPB]) mism++;
                pos++;
                if (pos == NBITS * CPB) begin
                    chk($sformatf("frame_%02h_bad_cycles", cur), mism, 0);
                    frames_done++;
                    pos = -1;
                end
            end
        end

        initial begin
            int r0;
            int f0;
            int c0;
            int bad;

            // Reset asserted between edges acts at once and holds.
            #2 rst = 1'b1;
            #1;
            chk("rst_tx", tx, 1);
            chk("rst_re", fifo_re, 0);
            chk("rst_busy", busy, 0);
            push(8'h5A);
            en = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst_hold_tx", tx, 1);
            chk("rst_hold_re", fifo_re, 0);
            chk("rst_hold_busy", busy, 0);
            chk("rst_state", state_dbg, 0);
            chk("rst_no_reads", re_cnt, 0);
            en  = 1'b0;
            rst = 1'b0;
            @(negedge clk);
            en = 1'b1;
            wait_frames(1, "after_reset_frame");

            // Empty FIFO with enable high: no reads, line idle.
            repeat (4) @(negedge clk);
            r0  = re_cnt;
            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (tx !== 1'b1 || fifo_re !== 1'b0) bad++;
            end
            chk("empty_idle_bad_cycles", bad, 0);
            chk("empty_no_reads", re_cnt - r0, 0);

            // Single word, first-start latency, busy.
            f0 = frames_done;
            r0 = re_cnt;
            c0 = cyc;
            push(8'hA5);
            repeat (10) @(negedge clk);
            chk("busy_mid_frame", busy, 1);
            wait_frames(f0 + 1, "single_frame");
            chk("start_latency", start_cyc - c0, 4);
            chk("single_reads", re_cnt - r0, 1);
            repeat (2) @(negedge clk);
            chk("busy_after", busy, 0);

            // Back-to-back frames.
            f0 = frames_done;
            r0 = re_cnt;
            push(8'h3C);
            push(8'hC3);
            wait_frames(f0 + 2, "b2b_frames");
            chk("b2b_gap", last_gap, 3);
            chk("b2b_reads", re_cnt - r0, 2);
            repeat (2) @(negedge clk);
            chk("b2b_fifo_empty", fifo_empty, 1);

            // Ninth line bit: parity on lane 1, stop bit on lane 0.
            f0 = frames_done;
            push(8'hA5);
            wait_frames(f0 + 1, "par_a5_frame");
            chk("bit9_a5", bit9, PE ? 32'd0 : 32'd1);
            push(8'h01);
            wait_frames(f0 + 2, "par_01_frame");
            chk("bit9_01", bit9, PE ? 32'd1 : 32'd1);

            // Enable dropped during DATA: frame completes, no new read.
            f0 = frames_done;
            r0 = re_cnt;
            push(8'h96);
            push(8'h69);
            wait_pos(12, "en_drop_reach_data");
            en = 1'b0;
            wait_frames(f0 + 1, "en_drop_frame");
            repeat (40) @(negedge clk);
            chk("en_drop_reads", re_cnt - r0, 1);
            chk("en_drop_fifo_left", mem_q.size(), 1);
            chk("en_drop_no_frame", frames_done - f0, 1);
            en = 1'b1;
            wait_frames(f0 + 2, "en_back_frame");
            chk("en_back_reads", re_cnt - r0, 2);

            // Reset during bit 3 of 0xFF: word lost, next word intact.
            r0 = re_cnt;
            push(8'hFF);
            wait_pos(17, "rst_mid_reach_bit3");
            f0 = frames_done;
            #2 rst = 1'b1;
            #1;
            chk("rst_mid_tx", tx, 1);
            chk("rst_mid_busy", busy, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_mid_no_frame", frames_done, f0);
            push(8'h55);
            wait_frames(f0 + 1, "after_mid_rst_frame");
            chk("rst_mid_reads", re_cnt - r0, 2);

            // Random words, random spacing, enable toggling.
            f0 = frames_done;
            r0 = re_cnt;
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 60)) @(negedge clk);
                en = ($urandom_range(0, 4) != 0);
                push(8'($urandom));
            end
            @(negedge clk);
            en = 1'b1;
            wait_frames(f0 + 12, "rand_frames");
            chk("rand_reads", re_cnt - r0, 12);
            chk("exp_q_drained", exp_q.size(), 0);

            lane_done[g] = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(lane_done[0] && lane_done[1]) && t < 50000) begin
            @(negedge clk);
            t++;
        end
        check("all_lanes_finished", {30'b0, lane_done[1], lane_done[0]}, 32'h3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
